// File: rtl/shift_add_mult_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the FSM state encoding and the default operand width.
package shift_add_mult_seq_pkg;

   localparam int unsigned DEF_W = 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StRun  = ST_RUN,
      StDone = ST_DONE
   } state_e;

endpackage

// File: rtl/shift_add_mult_seq_shl1.sv
// Combinational left shift by one bit: the MSB is dropped and a 0 enters at the LSB.
// Ports:
//   din  - N-bit input word
//   dout - din shifted left by one
module shl1_w #(
   parameter int unsigned N = 10
) (
   input  logic [N-1:0] din,
   output logic [N-1:0] dout
);

   assign dout = {din[N-2:0], 1'b0};

endmodule

// File: rtl/shift_add_mult_seq.sv
// Iterative unsigned shift-and-add multiplier. One partial product is examined
// per cycle, so a W x W multiply takes W cycles in RUN plus one DONE cycle.
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst     - synchronous active-high reset
//   start   - request a multiply, accepted only while ready=1
//   a, b    - multiplicand / multiplier, captured when start is accepted
//   ready   - high only in IDLE
//   busy    - high in RUN and DONE
//   done    - one-cycle pulse when product has just been updated
//   product - last completed product, held until the next operation completes
module shift_add_mult_seq
   import shift_add_mult_seq_pkg::*;
#(
   parameter int unsigned W  = DEF_W,
   parameter int unsigned CW = $clog2(W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [2*W-1:0]   product
);

   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_e            state_q;
   logic [2*W-1:0]    m_q;
   logic [W-1:0]      q_q;
   logic [2*W-1:0]    acc_q;
   logic [CW-1:0]     cnt_q;
   logic              ready_q;
   logic              busy_q;
   logic              done_q;
   logic [2*W-1:0]    product_q;

   logic [2*W-1:0]    m_shl;
   logic [2*W-1:0]    acc_nxt;

   shl1_w #(
      .N (2 * W)
   ) u_shl1 (
      .din  (m_q),
      .dout (m_shl)
   );

   // Accumulate the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      acc_nxt = acc_q;
      if (q_q[0]) begin
         acc_nxt = acc_q + m_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         m_q       <= '0;
         q_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  m_q     <= {{W{1'b0}}, a};
                  q_q     <= b;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               acc_q <= acc_nxt;
               m_q   <= m_shl;
               q_q   <= q_q >> 1;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  // Use this cycle's sum so the final partial product is included.
                  product_q <= acc_nxt;
                  done_q    <= 1'b1;
                  state_q   <= StDone;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign ready   = ready_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Directed testbench for shift_add_mult_seq (W=5).
module tb_shift_add_mult_seq;

   localparam int unsigned W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [2*W-1:0]   product;

   int tests = 0;
   int fails = 0;

   shift_add_mult_seq #(
      .W (W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Start in cycle c, check RUN in c+1..c+5, done/product at c+6, back to IDLE at c+7.
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [2*W-1:0] exp_p, input logic [2*W-1:0] old_p,
                         input string tag);
      a = ia;
      b = ib;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         chk({tag, " done_low"}, done, 0);
         chk({tag, " prod_held"}, product, old_p);
         if (i == 1) begin
            chk({tag, " busy"}, busy, 1);
            chk({tag, " ready_low"}, ready, 0);
         end
         tick();
      end
      chk({tag, " done_pulse"}, done, 1);
      chk({tag, " product"}, product, exp_p);
      chk({tag, " ready_in_done"}, ready, 0);
      tick();
      chk({tag, " done_fell"}, done, 0);
      chk({tag, " ready_back"}, ready, 1);
      chk({tag, " busy_fell"}, busy, 0);
      chk({tag, " product_kept"}, product, exp_p);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      tick();
      tick();
      chk("reset ready", ready, 1);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset product", product, 0);
      rst = 1'b0;
      tick();
      chk("idle ready", ready, 1);

      run_op(5'd13, 5'd11, 10'd143, 10'd0, "basic");
      run_op(5'd31, 5'd31, 10'h3C1, 10'd143, "max");
      run_op(5'd0, 5'd31, 10'd0, 10'h3C1, "zero_a");
      run_op(5'd9, 5'd6, 10'd54, 10'd0, "mid");

      // start held continuously: second op accepted in c+7, done in c+13
      a = 5'd3;
      b = 5'd5;
      start = 1'b1;
      tick();
      for (int i = 1; i <= 5; i++) begin
         chk("held done_low1", done, 0);
         tick();
      end
      chk("held done1", done, 1);
      chk("held product1", product, 15);
      for (int i = 7; i <= 12; i++) begin
         tick();
         chk("held done_low2", done, 0);
         chk("held prod_hold", product, 15);
         if (i == 7) chk("held ready_c7", ready, 1);
         if (i == 8) chk("held busy_c8", busy, 1);
      end
      tick();
      chk("held done2", done, 1);
      chk("held product2", product, 15);
      start = 1'b0;
      tick();
      chk("held idle", ready, 1);

      // operands changed during RUN must not matter
      a = 5'd7;
      b = 5'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = 5'd31;
      b = 5'd31;
      for (int i = 1; i <= 5; i++) tick();
      chk("opchg done", done, 1);
      chk("opchg product", product, 63);
      tick();

      // reset in c+3 aborts the op with no done pulse
      a = 5'd20;
      b = 5'd20;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort ready", ready, 1);
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort product", product, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort no_done", done, 0);
      end
      run_op(5'd2, 5'd3, 10'd6, 10'd0, "after_abort");

      // rst wins over start in the same cycle
      a = 5'd4;
      b = 5'd4;
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      chk("rst_start ready", ready, 1);
      chk("rst_start busy", busy, 0);
      chk("rst_start product", product, 0);
      tick();
      chk("rst_start still_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
